// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reserved instruction encodings and IF stage state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    // All-zero word is the canonical bubble; all-ones is the simulator-private HALT.
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IF_IDLE   = 2'd0,
        IF_RUN    = 2'd1,
        IF_STEP   = 2'd2,
        IF_HALTED = 2'd3
    } if_state_t;

endpackage : mips_pkg

// File: rtl/instruction_memory.sv
// Word-addressed instruction store, one synchronous write port, one asynchronous read port.
// Latency: write lands on the clock edge; read is combinational from the address.
// Backpressure: none; the caller gates the write strobe.
//  Ports: i_clk, i_we/i_waddr/i_wdata (write), i_raddr -> o_rdata (read).
module instruction_memory #(
    parameter int IMEM_DEPTH = 256,
    parameter int IMEM_AW    = 8
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [IMEM_AW-1:0] i_waddr,
    input  logic [31:0]        i_wdata,
    input  logic [IMEM_AW-1:0] i_raddr,
    output logic [31:0]        o_rdata
);

    // No reset: program contents must survive a pipeline reset.
    logic [31:0] mem [IMEM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule : instruction_memory

// File: rtl/instruction_fetch.sv
// IF stage: PC, instruction memory, IF/ID register, run/step/halt control.
// Latency: one cycle from PC to IF/ID; a taken jump costs one NOP bubble.
// Backpressure: i_stall (or a missing step pulse) freezes PC and IF/ID, o_advance low.
//  Ports: i_clk/i_reset; debug load (i_load_*), i_start/i_step_mode/i_step;
//  hazard i_stall; ID redirect i_jump/i_jump_address; IF/ID o_instruction/o_pc/o_advance;
//  status o_halted/o_running.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int IMEM_AW    = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load_we,
    input  logic [IMEM_AW-1:0] i_load_addr,
    input  logic [31:0]        i_load_data,
    input  logic               i_start,
    input  logic               i_step_mode,
    input  logic               i_step,
    input  logic               i_stall,
    input  logic               i_jump,
    input  logic [31:0]        i_jump_address,
    output logic [31:0]        o_instruction,
    output logic [31:0]        o_pc,
    output logic               o_advance,
    output logic               o_halted,
    output logic               o_running
);

    if_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        advance_q, advance_d;
    logic [31:0] fetch_word;
    logic        en;

    // Loads are only accepted while the machine is parked.
    instruction_memory #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .IMEM_AW    (IMEM_AW)
    ) u_imem (
        .i_clk   (i_clk),
        .i_we    (i_load_we && (state_q == IF_IDLE)),
        .i_waddr (i_load_addr),
        .i_wdata (i_load_data),
        .i_raddr (pc_q[IMEM_AW+1:2]),
        .o_rdata (fetch_word)
    );

    assign en = (state_q == IF_RUN) || ((state_q == IF_STEP) && i_step);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        if_pc_d   = if_pc_q;
        advance_d = 1'b0;

        case (state_q)
            IF_IDLE: begin
                if (i_start) begin
                    state_d = i_step_mode ? IF_STEP : IF_RUN;
                end
            end
            IF_RUN, IF_STEP: begin
                // A stalled cycle ignores i_jump: ID holds the branch and re-asserts it.
                if (en && !i_stall) begin
                    advance_d = 1'b1;
                    if_pc_d   = pc_q;
                    if (i_jump) begin
                        // Squash the wrong-path word; no delay slot.
                        pc_d    = i_jump_address;
                        instr_d = NOP_INSTR;
                    end else begin
                        instr_d = fetch_word;
                        if (fetch_word == HALT_INSTR) begin
                            state_d = IF_HALTED;
                        end else begin
                            pc_d = pc_q + 32'd4;
                        end
                    end
                end
            end
            default: ; // HALTED: everything frozen until reset
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IF_IDLE;
            pc_q      <= 32'd0;
            instr_q   <= NOP_INSTR;
            if_pc_q   <= 32'd0;
            advance_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            if_pc_q   <= if_pc_d;
            advance_q <= advance_d;
        end
    end

    assign o_instruction = instr_q;
    assign o_pc          = if_pc_q;
    assign o_advance     = advance_q;
    assign o_halted      = (state_q == IF_HALTED);
    assign o_running     = (state_q == IF_RUN) || (state_q == IF_STEP);

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: run/halt, jump squash, stall, step, squashed HALT, reset.
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns after the following posedge.
// Backpressure: exercised through i_stall and i_step gaps.
module tb_instruction_fetch;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] W0   = 32'h2001_0005; // addi $1,$0,5
    localparam logic [31:0] W1   = 32'h2002_0003; // addi $2,$0,3
    localparam logic [31:0] W2   = 32'h0022_1820; // add  $3,$1,$2
    localparam logic [31:0] W3   = 32'h2004_0009;
    localparam logic [31:0] J16  = 32'h2005_0007;
    localparam logic [31:0] T0   = 32'h2006_0001;
    localparam logic [31:0] T1   = 32'h2007_0002;

    logic        i_clk = 1'b0;
    logic        i_reset, i_load_we, i_start, i_step_mode, i_step, i_stall, i_jump;
    logic [7:0]  i_load_addr;
    logic [31:0] i_load_data, i_jump_address;
    logic [31:0] o_instruction, o_pc;
    logic        o_advance, o_halted, o_running;

    int tests  = 0;
    int failed = 0;

    instruction_fetch #(.IMEM_DEPTH(256), .IMEM_AW(8)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_load_we      (i_load_we),
        .i_load_addr    (i_load_addr),
        .i_load_data    (i_load_data),
        .i_start        (i_start),
        .i_step_mode    (i_step_mode),
        .i_step         (i_step),
        .i_stall        (i_stall),
        .i_jump         (i_jump),
        .i_jump_address (i_jump_address),
        .o_instruction  (o_instruction),
        .o_pc           (o_pc),
        .o_advance      (o_advance),
        .o_halted       (o_halted),
        .o_running      (o_running)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        i_load_we   = 1'b1;
        i_load_addr = a;
        i_load_data = d;
        tick();
        i_load_we   = 1'b0;
    endtask

    task automatic start(input logic step_mode);
        i_start     = 1'b1;
        i_step_mode = step_mode;
        tick();
        i_start     = 1'b0;
        i_step_mode = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (o_instruction !== NOP) begin failed++; $display("FAIL reset_instr got %h exp %h", o_instruction, NOP); end
        tests++; if (o_pc !== 32'd0) begin failed++; $display("FAIL reset_pc got %h exp 0", o_pc); end
        tests++; if (o_advance !== 1'b0) begin failed++; $display("FAIL reset_adv got %b exp 0", o_advance); end
        tests++; if (o_halted !== 1'b0) begin failed++; $display("FAIL reset_halted got %b exp 0", o_halted); end
        tests++; if (o_running !== 1'b0) begin failed++; $display("FAIL reset_running got %b exp 0", o_running); end
    endtask

    task automatic test_run_halt();
        logic [31:0] exp_w [4];
        exp_w[0] = W0; exp_w[1] = W1; exp_w[2] = W2; exp_w[3] = HALT;
        do_reset();
        load(8'd0, W0); load(8'd1, W1); load(8'd2, W2); load(8'd3, HALT);
        tick();
        tests++; if (o_advance !== 1'b0 || o_running !== 1'b0) begin failed++; $display("FAIL idle_hold adv %b run %b exp 0 0", o_advance, o_running); end
        start(1'b0);
        tests++; if (o_running !== 1'b1 || o_advance !== 1'b0) begin failed++; $display("FAIL run_entry run %b adv %b exp 1 0", o_running, o_advance); end
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (o_pc !== 32'(k * 4) || o_instruction !== exp_w[k] || o_advance !== 1'b1) begin
                failed++; $display("FAIL run_fetch%0d pc %h instr %h adv %b exp %h %h 1", k, o_pc, o_instruction, o_advance, k * 4, exp_w[k]);
            end
        end
        tests++; if (o_halted !== 1'b1 || o_running !== 1'b0) begin failed++; $display("FAIL halt_edge halted %b run %b exp 1 0", o_halted, o_running); end
        i_step = 1'b1; i_start = 1'b1; i_jump = 1'b1; i_jump_address = 32'h40;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (o_pc !== 32'd12 || o_instruction !== HALT || o_advance !== 1'b0 || o_halted !== 1'b1) begin
                failed++; $display("FAIL halted_frozen%0d pc %h instr %h adv %b halted %b exp c ffffffff 0 1", k, o_pc, o_instruction, o_advance, o_halted);
            end
        end
        i_step = 1'b0; i_start = 1'b0; i_jump = 1'b0;
    endtask

    task automatic test_jump();
        do_reset();
        load(8'd3, W3); load(8'd16, J16); load(8'd17, HALT);
        start(1'b0);
        tick(); tick(); // o_pc 0, 4; pc now 8
        tests++; if (o_pc !== 32'd4 || o_instruction !== W1) begin failed++; $display("FAIL jump_pre pc %h instr %h exp 4 %h", o_pc, o_instruction, W1); end
        i_jump = 1'b1; i_jump_address = 32'h40;
        tick();
        i_jump = 1'b0;
        tests++; if (o_pc !== 32'd8 || o_instruction !== NOP || o_advance !== 1'b1) begin failed++; $display("FAIL jump_bubble pc %h instr %h adv %b exp 8 0 1", o_pc, o_instruction, o_advance); end
        tick();
        tests++; if (o_pc !== 32'h40 || o_instruction !== J16) begin failed++; $display("FAIL jump_target pc %h instr %h exp 40 %h", o_pc, o_instruction, J16); end
        tick();
        tests++; if (o_pc !== 32'h44 || o_halted !== 1'b1) begin failed++; $display("FAIL jump_then_halt pc %h halted %b exp 44 1", o_pc, o_halted); end
    endtask

    task automatic test_stall();
        do_reset();
        start(1'b0);
        tick(); // o_pc 0, pc 4
        i_stall = 1'b1; i_jump = 1'b1; i_jump_address = 32'h40;
        for (int k = 0; k < 2; k++) begin
            tick();
            tests++;
            if (o_pc !== 32'd0 || o_instruction !== W0 || o_advance !== 1'b0) begin
                failed++; $display("FAIL stall_hold%0d pc %h instr %h adv %b exp 0 %h 0", k, o_pc, o_instruction, o_advance, W0);
            end
        end
        i_stall = 1'b0;
        tick();
        i_jump = 1'b0;
        tests++; if (o_pc !== 32'd4 || o_instruction !== NOP || o_advance !== 1'b1) begin failed++; $display("FAIL stall_release pc %h instr %h adv %b exp 4 0 1", o_pc, o_instruction, o_advance); end
        tick();
        tests++; if (o_pc !== 32'h40 || o_instruction !== J16) begin failed++; $display("FAIL stall_redirect pc %h instr %h exp 40 %h", o_pc, o_instruction, J16); end
    endtask

    task automatic test_step();
        logic [31:0] exp_w [3];
        exp_w[0] = W0; exp_w[1] = W1; exp_w[2] = W2;
        do_reset();
        start(1'b1);
        tick(); tick();
        tests++; if (o_running !== 1'b1 || o_advance !== 1'b0 || o_pc !== 32'd0 || o_instruction !== NOP) begin
            failed++; $display("FAIL step_idle run %b adv %b pc %h instr %h exp 1 0 0 0", o_running, o_advance, o_pc, o_instruction);
        end
        for (int k = 0; k < 3; k++) begin
            i_step = 1'b1;
            tick();
            i_step = 1'b0;
            tests++;
            if (o_pc !== 32'(k * 4) || o_instruction !== exp_w[k] || o_advance !== 1'b1) begin
                failed++; $display("FAIL step_pulse%0d pc %h instr %h adv %b exp %h %h 1", k, o_pc, o_instruction, o_advance, k * 4, exp_w[k]);
            end
            tick(); tick();
            tests++;
            if (o_pc !== 32'(k * 4) || o_advance !== 1'b0) begin
                failed++; $display("FAIL step_gap%0d pc %h adv %b exp %h 0", k, o_pc, o_advance, k * 4);
            end
        end
    endtask

    task automatic test_squashed_halt();
        do_reset();
        load(8'd1, HALT); load(8'd8, T0); load(8'd9, T1);
        start(1'b0);
        tick(); // o_pc 0, pc 4 (HALT next)
        i_jump = 1'b1; i_jump_address = 32'h20;
        tick();
        i_jump = 1'b0;
        tests++; if (o_pc !== 32'd4 || o_instruction !== NOP || o_halted !== 1'b0) begin failed++; $display("FAIL sq_halt_bubble pc %h instr %h halted %b exp 4 0 0", o_pc, o_instruction, o_halted); end
        tick();
        tests++; if (o_pc !== 32'h20 || o_instruction !== T0 || o_halted !== 1'b0) begin failed++; $display("FAIL sq_halt_target pc %h instr %h halted %b exp 20 %h 0", o_pc, o_instruction, o_halted, T0); end
        tick();
        tests++; if (o_pc !== 32'h24 || o_instruction !== T1 || o_running !== 1'b1) begin failed++; $display("FAIL sq_halt_cont pc %h instr %h run %b exp 24 %h 1", o_pc, o_instruction, o_running, T1); end
    endtask

    task automatic test_mid_run_reset();
        do_reset();
        start(1'b0);
        // Write attempted while running must be dropped.
        i_load_we = 1'b1; i_load_addr = 8'd0; i_load_data = 32'hDEAD_BEEF;
        tick();
        i_load_we = 1'b0;
        tests++; if (o_pc !== 32'd0 || o_instruction !== W0) begin failed++; $display("FAIL mid_pre pc %h instr %h exp 0 %h", o_pc, o_instruction, W0); end
        do_reset();
        tests++; if (o_pc !== 32'd0 || o_instruction !== NOP || o_advance !== 1'b0 || o_running !== 1'b0 || o_halted !== 1'b0) begin
            failed++; $display("FAIL mid_reset pc %h instr %h adv %b run %b halted %b exp all 0", o_pc, o_instruction, o_advance, o_running, o_halted);
        end
        start(1'b0);
        tick();
        tests++; if (o_pc !== 32'd0 || o_instruction !== W0) begin failed++; $display("FAIL restart0 pc %h instr %h exp 0 %h", o_pc, o_instruction, W0); end
        tick();
        tests++; if (o_pc !== 32'd4 || o_instruction !== HALT || o_halted !== 1'b1) begin failed++; $display("FAIL restart1 pc %h instr %h halted %b exp 4 ffffffff 1", o_pc, o_instruction, o_halted); end
    endtask

    initial begin
        i_reset = 1'b1; i_load_we = 1'b0; i_load_addr = '0; i_load_data = '0;
        i_start = 1'b0; i_step_mode = 1'b0; i_step = 1'b0; i_stall = 1'b0;
        i_jump = 1'b0; i_jump_address = '0;
        test_reset();
        test_run_halt();
        test_jump();
        test_stall();
        test_step();
        test_squashed_halt();
        test_mid_run_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_instruction_fetch
